wb_bank_responder: RTL and testbench
====================================

# wb_bank_responder

Pipelined Wishbone slave that answers one memory bank behind the memory-system interconnect: it accepts strobes from the interconnect's per-bank master port, performs byte-enabled reads/writes on a local word array, and returns ack/err after a fixed latency. It also models periodic DRAM-style refresh by stalling the bus for a fixed window, so upstream stall handling and the RW/RO arbitration are exercised under back-pressure.

## Interface
- MW, 64, data width in bits
- AW, 32, address width in bits
- BW, MW/8, byte-enable width
- BASE, 'h20000000, first byte address of the bank
- DEPTH, 1024, number of MW-bit words (power of two)
- LAT, 2, accept-to-response latency in cycles (1..4)
- REFRESH_PERIOD, 256, RUN cycles between refreshes; 0 disables refresh
- REFRESH_CYCLES, 4, stall window length (>=1 when refresh is enabled)

- i_clk  in  1  clock, all state updates on the rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_addr  in  AW  byte address
- i_wb_data  in  MW  write data
- i_wb_be  in  BW  byte enables; bit k covers data[8k+7:8k]
- o_wb_stall  out  1  request cannot be accepted this cycle
- o_wb_ack  out  1  one-cycle successful response
- o_wb_err  out  1  one-cycle error response
- o_wb_data  out  MW  read data, valid with o_wb_ack

## Operation
- Accept = i_wb_stb && !o_wb_stall, sampled at the rising edge. There is no cyc input; every accepted strobe gets exactly one response (ack or err).
- Offset = i_wb_addr - BASE (AW-bit unsigned). Request valid iff i_wb_addr >= BASE, offset < DEPTH*BW, and offset[log2(BW)-1:0] == 0. Word index = offset >> log2(BW).
- Valid write: at the accept edge, mem[index] byte k <= i_wb_data byte k for each set i_wb_be[k]; i_wb_be == 0 is a valid no-op write. Response: ack, o_wb_data = 0.
- Valid read: mem[index] is captured at the accept edge and carried down the pipeline. A read accepted one cycle after a write to the same word returns the written data. Response: ack with the captured data.
- Invalid request: no memory change. Response: err, ack low, o_wb_data = 0.
- Response pipeline: LAT stages of {valid, is_err, data}, advancing every cycle and never stalled. Stall only blocks new accepts; in-flight responses always complete.
- Refresh FSM, states RUN and REFRESH, with cycle counter cnt:
  - RUN: cnt increments each cycle. When REFRESH_PERIOD > 0 and cnt == REFRESH_PERIOD-1, the next state is REFRESH and cnt resets to 0.
  - REFRESH: cnt increments each cycle. When cnt == REFRESH_CYCLES-1, the next state is RUN and cnt resets to 0.
  - o_wb_stall is registered and is 1 exactly while in REFRESH.
  - A strobe in the last RUN cycle, with stall still low, is accepted normally.
- Memory contents are not reset and are X until written.

## Timing
- Reset (i_reset_n low, asynchronous):
  - state = RUN, cnt = 0, all pipeline valids = 0.
  - o_wb_stall = 0, o_wb_ack = 0, o_wb_err = 0, o_wb_data = 0.
- Reset mid-operation drops all in-flight responses; no ack or err is issued for them.
- Request accepted at edge T: its ack or err is high during the cycle following edge T+LAT-1. Example: with LAT=1, the response appears the cycle right after the accept.
- Throughput: one accept per cycle while not stalled. Back-to-back responses appear on consecutive cycles, in order.
- o_wb_ack and o_wb_err are never high in the same cycle. Both are low in every cycle that has no response due.
- With REFRESH_PERIOD=P and REFRESH_CYCLES=R:
  - After reset, stall is low for P cycles, then high for R cycles, repeating.
  - A refresh window starts P cycles after the end of the previous one.
- o_wb_data = 0 in every cycle where o_wb_ack is low.

## Test plan
- Write then read, LAT=2, BASE='h20000000: write 'h1122334455667788 at 'h20000008 with be='hFF, then read the same address on the next cycle -> two acks on consecutive cycles; the second returns 'h1122334455667788.
- Byte enables: preload the word with 'hFFFFFFFFFFFFFFFF, write 'h0 with be='h0F, then read -> data 'hFFFFFFFF00000000.
- Errors:
  - read at 'h1FFFFFF8 -> err 2 cycles later, no ack.
  - write at 'h20000004 (misaligned) -> err, and the word at 'h20000000 is unchanged.
  - read at BASE+DEPTH*8 -> err.
- Refresh with P=8, R=3: hold stb high on reads -> stall high in cycles 8-10 after reset, no accepts during those cycles, exactly 8 acks per 11-cycle period, all in-flight acks delivered during the stall.
- Pipelining: 4 back-to-back reads of distinct words -> 4 consecutive acks in request order with the correct data.
- Reset mid-flight: accept a read, drop i_reset_n for 1 cycle before its response -> no ack, all outputs 0, stall 0; a new request after reset completes normally.

Source files
------------

// File: rtl/wb_bank_responder.sv
// wb_bank_responder: pipelined Wishbone bank slave with byte-enabled word array, fixed-latency responses and periodic refresh stall
module wb_bank_responder #(
  parameter int MW = 64,
  parameter int AW = 32,
  parameter int BW = MW / 8,
  parameter logic [AW-1:0] BASE = 'h20000000,
  parameter int DEPTH = 1024,
  parameter int LAT = 2,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [MW-1:0] i_wb_data,
  input  logic [BW-1:0] i_wb_be,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  output logic [MW-1:0] o_wb_data
);
  localparam int OW = $clog2(BW);
  localparam int IW = $clog2(DEPTH);
  localparam int CMAX = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [AW-1:0] SPAN = AW'(DEPTH * BW);

  typedef enum logic {RUN, REFRESH} state_t;

  state_t                 r_state, w_state;
  logic [CW-1:0]          r_cnt, w_cnt;
  logic [MW-1:0]          r_mem [DEPTH];
  logic [LAT-1:0]         r_vld, r_err;
  logic [LAT-1:0][MW-1:0] r_dat;
  logic [AW-1:0]          w_off;
  logic [IW-1:0]          w_idx;
  logic                   w_ok, w_acc;

  assign w_off = i_wb_addr - BASE;
  assign w_ok  = (i_wb_addr >= BASE) && (w_off < SPAN) && (w_off[OW-1:0] == '0);
  assign w_idx = w_off[OW +: IW];
  assign w_acc = i_wb_stb && !o_wb_stall;

  assign o_wb_stall = (r_state == REFRESH);
  assign o_wb_ack   = r_vld[LAT-1] && !r_err[LAT-1];
  assign o_wb_err   = r_vld[LAT-1] && r_err[LAT-1];
  assign o_wb_data  = r_dat[LAT-1];

  // byte-enabled write into the word array; contents are intentionally never reset
  always_ff @(posedge i_clk) begin
    if (w_acc && w_ok && i_wb_we)
      for (int k = 0; k < BW; k++)
        if (i_wb_be[k]) r_mem[w_idx][8*k +: 8] <= i_wb_data[8*k +: 8];
  end

  // response pipeline: stage 0 captures the outcome at accept, later stages shift every cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vld <= '0;
      r_err <= '0;
      r_dat <= '0;
    end else begin
      r_vld[0] <= w_acc;
      r_err[0] <= w_acc && !w_ok;
      r_dat[0] <= (w_acc && w_ok && !i_wb_we) ? r_mem[w_idx] : '0;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  // refresh state and cycle counter register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
    end
  end

  // refresh next state: RUN for REFRESH_PERIOD cycles, then REFRESH for REFRESH_CYCLES cycles
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 1'b1;
    if (r_state == RUN && REFRESH_PERIOD > 0 && r_cnt == CW'(REFRESH_PERIOD - 1)) begin
      w_state = REFRESH;
      w_cnt   = '0;
    end else if (r_state == REFRESH && r_cnt == CW'(REFRESH_CYCLES - 1)) begin
      w_state = RUN;
      w_cnt   = '0;
    end
  end
endmodule

// File: tb/tb_wb_bank_responder.sv
// tb_wb_bank_responder: scoreboard bench with directed requests, refresh-window and mid-flight reset checks
module tb_wb_bank_responder;
  localparam int LAT = 2;
  localparam int P = 8;
  localparam int R = 3;

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 0, rst_n = 0;
  logic        stb = 0, we = 0;
  logic [31:0] addr = 0;
  logic [63:0] wdata = 0;
  logic [7:0]  be = 0;
  logic        stall, ack, err;
  logic [63:0] rdata;
  int          cyc = 0;
  int          checks = 0, failures = 0;
  exp_t        q[$];

  wb_bank_responder #(.LAT(LAT), .REFRESH_PERIOD(P), .REFRESH_CYCLES(R)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdata), .i_wb_be(be), .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err),
    .o_wb_data(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every response must match the oldest outstanding expectation, at the right cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (!ack) check("data_zero_without_ack", rdata, 64'h0);
      if (ack || err) begin
        check("ack_err_exclusive", {63'h0, ack & err}, 64'h0);
        if (q.size() == 0) check("unexpected_response", 64'h1, 64'h0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("resp_is_err", {63'h0, err}, {63'h0, e.err});
          check("resp_data", rdata, e.data);
          check("resp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic req(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] b,
                     input logic e, input logic [63:0] rd);
    int n = 0;
    @(negedge clk);
    stb = 1; we = w; addr = a; wdata = d; be = b;
    while (stall && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (stall) check("stall_timeout", 64'h1, 64'h0);
    q.push_back('{e, rd, cyc + LAT});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    stb = 0; we = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_stall"}, {63'h0, stall}, 64'h0);
    check({name, "_ack"}, {63'h0, ack}, 64'h0);
    check({name, "_err"}, {63'h0, err}, 64'h0);
    check({name, "_data"}, rdata, 64'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1;
    req(1, 32'h20000008, 64'h1122334455667788, 8'hFF, 0, 64'h0);
    req(0, 32'h20000008, 64'h0, 8'hFF, 0, 64'h1122334455667788);
    req(1, 32'h20000010, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 64'h0);
    req(1, 32'h20000010, 64'h0, 8'h0F, 0, 64'h0);
    req(0, 32'h20000010, 64'h0, 8'h00, 0, 64'hFFFFFFFF00000000);
    req(1, 32'h20000000, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 0, 64'h0);
    req(0, 32'h1FFFFFF8, 64'h0, 8'hFF, 1, 64'h0);
    req(1, 32'h20000004, 64'h0, 8'hFF, 1, 64'h0);
    req(0, 32'h20000000, 64'h0, 8'h00, 0, 64'hA5A5A5A5A5A5A5A5);
    req(0, 32'h20002000, 64'h0, 8'h00, 1, 64'h0);
    req(1, 32'h20001FF8, 64'h0123456789ABCDEF, 8'hFF, 0, 64'h0);
    req(0, 32'h20001FF8, 64'h0, 8'h00, 0, 64'h0123456789ABCDEF);
    req(1, 32'h20000018, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, 64'h0);
    req(1, 32'h20000018, 64'h0, 8'h00, 0, 64'h0);
    idle(LAT + 2);
    req(0, 32'h20000000, 64'h0, 8'h00, 0, 64'hA5A5A5A5A5A5A5A5);
    req(0, 32'h20000008, 64'h0, 8'h00, 0, 64'h1122334455667788);
    req(0, 32'h20000010, 64'h0, 8'h00, 0, 64'hFFFFFFFF00000000);
    req(0, 32'h20000018, 64'h0, 8'h00, 0, 64'hDEADBEEFCAFEF00D);
    idle(LAT + 2);
    check("drained_before_reset", 64'(q.size()), 64'h0);
    req(0, 32'h20000000, 64'h0, 8'h00, 0, 64'hA5A5A5A5A5A5A5A5);
    @(negedge clk);
    stb = 0;
    rst_n = 0;
    q.delete();
    #1;
    check_quiet("midflight_reset");
    @(negedge clk);
    rst_n = 1;
    repeat (LAT + 2) @(negedge clk);
    req(0, 32'h20000008, 64'h0, 8'h00, 0, 64'h1122334455667788);
    idle(LAT + 2);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int j = 0; j < 2 * (P + R); j++) begin
      check("refresh_stall", {63'h0, stall}, {63'h0, ((j % (P + R)) >= P)});
      stb = 1; we = 0; addr = 32'h20000000;
      if (!stall) q.push_back('{1'b0, 64'hA5A5A5A5A5A5A5A5, cyc + LAT});
      @(negedge clk);
    end
    stb = 0;
    repeat (LAT + 2) @(negedge clk);
    check("all_responses_delivered", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
